// File: rtl/full_adder_pkg.sv
// Shared constants for the full_adder slice.
package full_adder_pkg;
    localparam int unsigned DEFAULT_WIDTH = 1;
endpackage

// File: rtl/full_adder_half_adder.sv
// Gate-level half adder cell: sum = x ^ y, carry = x & y.
module half_adder (
    input  logic x,
    input  logic y,
    output logic sum,
    output logic carry
);
    assign sum   = x ^ y;
    assign carry = x & y;
endmodule

// File: rtl/full_adder.sv
// WIDTH-bit ripple-carry adder built from half_adder cells.
// Combinational sum/carry-out, plus registered copies.
module full_adder
    import full_adder_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] s,
    output logic             cout,
    output logic [WIDTH-1:0] s_q,
    output logic             cout_q
);
    logic [WIDTH:0]   c;
    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] s_d;
    logic             cout_d;

    assign c[0] = cin;

    // Each bit cell: propagate/generate half adder, then carry-merge half adder.
    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        logic p;
        logic g0;
        logic g1;

        half_adder u_ha_ab (
            .x     (a[i]),
            .y     (b[i]),
            .sum   (p),
            .carry (g0)
        );

        half_adder u_ha_pc (
            .x     (p),
            .y     (c[i]),
            .sum   (sum[i]),
            .carry (g1)
        );

        assign c[i+1] = g0 | g1;
    end

    assign s    = sum;
    assign cout = c[WIDTH];

    always_comb begin
        s_d    = s;
        cout_d = cout;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s_q    <= '0;
            cout_q <= 1'b0;
        end else begin
            s_q    <= s_d;
            cout_q <= cout_d;
        end
    end
endmodule

// File: tb/tb_full_adder.sv
// Self-checking bench for full_adder at WIDTH=1 and WIDTH=4.
module tb_full_adder;
    logic       clk;
    logic       rst;
    logic       a1, b1, cin1;
    logic       s1, cout1, s_q1, cout_q1;
    logic [3:0] a4, b4;
    logic       cin4;
    logic [3:0] s4, s_q4;
    logic       cout4, cout_q4;

    int unsigned n_cmp;
    int unsigned n_fail;

    typedef struct {
        logic a, b, cin;
        logic s, cout;
    } vec1_t;

    typedef struct {
        logic [3:0] a, b;
        logic       cin;
        logic [3:0] s;
        logic       cout;
    } vec4_t;

    vec1_t tv1[8];
    vec4_t tv4[2];

    full_adder #(.WIDTH(1)) dut1 (
        .clk    (clk),
        .rst    (rst),
        .a      (a1),
        .b      (b1),
        .cin    (cin1),
        .s      (s1),
        .cout   (cout1),
        .s_q    (s_q1),
        .cout_q (cout_q1)
    );

    full_adder #(.WIDTH(4)) dut4 (
        .clk    (clk),
        .rst    (rst),
        .a      (a4),
        .b      (b4),
        .cin    (cin4),
        .s      (s4),
        .cout   (cout4),
        .s_q    (s_q4),
        .cout_q (cout_q4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    initial begin
        logic [4:0] ref_sum;
        logic [4:0] prev_sum;
        n_cmp  = 0;
        n_fail = 0;

        tv1[0] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        tv1[1] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        tv1[2] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        tv1[3] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        tv1[4] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        tv1[5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        tv1[6] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        tv1[7] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        tv4[0] = '{4'hF, 4'h0, 1'b1, 4'h0, 1'b1};
        tv4[1] = '{4'h9, 4'h7, 1'b0, 4'h0, 1'b1};

        // Inputs left undriven for the first 100 ns.
        rst = 1'b0;
        #1 rst = 1'b1;
        #1;
        chk("reset_s_q1", 32'(s_q1), 32'd0);
        chk("reset_cout_q1", 32'(cout_q1), 32'd0);
        chk("reset_s_q4", 32'(s_q4), 32'd0);
        chk("reset_cout_q4", 32'(cout_q4), 32'd0);
        #98;
        a1 = 1'b0; b1 = 1'b0; cin1 = 1'b0;
        a4 = 4'h0; b4 = 4'h0; cin4 = 1'b0;
        #5;
        chk("driven_s1", 32'(s1), 32'd0);
        chk("driven_cout1", 32'(cout1), 32'd0);
        chk("zero_s4", 32'(s4), 32'd0);
        chk("zero_cout4", 32'(cout4), 32'd0);

        for (int i = 0; i < 8; i++) begin
            a1 = tv1[i].a; b1 = tv1[i].b; cin1 = tv1[i].cin;
            #5;
            chk($sformatf("tt%0d_s", i), 32'(s1), 32'(tv1[i].s));
            chk($sformatf("tt%0d_cout", i), 32'(cout1), 32'(tv1[i].cout));
            chk($sformatf("tt%0d_s_q_in_rst", i), 32'(s_q1), 32'd0);
            #5;
        end

        // Registered path after reset release.
        @(negedge clk);
        a1 = 1'b1; b1 = 1'b1; cin1 = 1'b0;
        rst = 1'b0;
        #1;
        chk("pre_edge_s_q1", 32'(s_q1), 32'd0);
        chk("pre_edge_cout_q1", 32'(cout_q1), 32'd0);
        @(posedge clk); #1;
        chk("cap11_s_q1", 32'(s_q1), 32'd0);
        chk("cap11_cout_q1", 32'(cout_q1), 32'd1);
        @(negedge clk);
        a1 = 1'b1; b1 = 1'b0; cin1 = 1'b0;
        @(posedge clk); #1;
        chk("cap10_s_q1", 32'(s_q1), 32'd1);
        chk("cap10_cout_q1", 32'(cout_q1), 32'd0);

        // Reset asserted between edges.
        #2 rst = 1'b1;
        #1;
        chk("midrst_s_q1", 32'(s_q1), 32'd0);
        chk("midrst_cout_q1", 32'(cout_q1), 32'd0);
        chk("midrst_s1", 32'(s1), 32'd1);
        chk("midrst_cout1", 32'(cout1), 32'd0);
        @(posedge clk); #1;
        chk("midrst_hold_s_q1", 32'(s_q1), 32'd0);
        chk("midrst_hold_cout_q1", 32'(cout_q1), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 2; i++) begin
            a4 = tv4[i].a; b4 = tv4[i].b; cin4 = tv4[i].cin;
            #2;
            chk($sformatf("w4_dir%0d_s", i), 32'(s4), 32'(tv4[i].s));
            chk($sformatf("w4_dir%0d_cout", i), 32'(cout4), 32'(tv4[i].cout));
        end

        // All-ones + all-ones + 1.
        a4 = 4'hF; b4 = 4'hF; cin4 = 1'b1;
        #2;
        chk("w4_max_s", 32'(s4), 32'hF);
        chk("w4_max_cout", 32'(cout4), 32'd1);

        prev_sum = '0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (i > 0) begin
                chk("rnd_s_q4", 32'(s_q4), 32'(prev_sum[3:0]));
                chk("rnd_cout_q4", 32'(cout_q4), 32'(prev_sum[4]));
            end
            a4   = 4'($urandom_range(0, 15));
            b4   = 4'($urandom_range(0, 15));
            cin4 = 1'($urandom_range(0, 1));
            ref_sum = 5'(a4) + 5'(b4) + 5'(cin4);
            #1;
            chk("rnd_sum4", 32'({cout4, s4}), 32'(ref_sum));
            prev_sum = ref_sum;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
